// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for the distributed FIFO. Pops words through a FIFO
// read port that has one cycle of read latency and re-presents them as a
// valid/ready stream. A 2-entry skid buffer sustains one word per clock under
// back-pressure. The stream is framed into bursts of BURST_LEN beats and the
// number of delivered beats is counted.
//
// Ports (all in the rd_clk domain):
//   rd_clk      in   sole clock
//   rd_rst      in   asynchronous, active-high reset
//   enable      in   allow new FIFO pops
//   rd_en       out  FIFO pop request (combinational)
//   rd_data     in   FIFO read data, valid the cycle after rd_en
//   empty       in   FIFO empty flag
//   out_valid   out  stream data valid
//   out_data    out  stream data (head of skid buffer)
//   out_last    out  last beat of the current burst
//   out_ready   in   stream consumer accepts
//   busy        out  a pop is in flight or the buffer is non-empty
//   word_cnt    out  beats accepted since reset, wraps
//   drain_state out  status-only drain FSM state (0=IDLE, 1=RUN, 2=DRAIN)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [1:0]            drain_state
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] BEAT_MAX = BCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf_q [0:1];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [BCW-1:0]        beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  state_e                state_q, state_d;

  logic                  pop_s;
  logic [2:0]            level_s;

  // Stream handshake, pop request and status outputs.
  always_comb begin
    pop_s     = (occ_q != 2'd0) & out_ready;
    // Words that will still be held after this cycle's pop; a new pop is only
    // safe while that leaves room for the word it returns next cycle.
    level_s   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    // rd_rst gates rd_en so no pop is issued while the engine is held in reset.
    rd_en     = enable & ~empty & ~rd_rst & (level_s < 3'd2);
    out_valid = (occ_q != 2'd0);
    out_data  = buf_q[head_q];
    out_last  = out_valid & (beat_q == BEAT_MAX);
    busy      = inflight_q | out_valid;
    word_cnt  = cnt_q;
    drain_state = state_q;
  end

  // Next-state for occupancy, pointers, burst framing, counter and FSM.
  always_comb begin
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    case ({inflight_q, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;       // idle, or capture and pop together
    endcase

    if (inflight_q) begin
      tail_d = ~tail_q;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (beat_q == BEAT_MAX) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BCW'(1);
      end
    end else begin
      head_d = head_q;
      cnt_d  = cnt_q;
      beat_d = beat_q;
    end

    // Status FSM simply tracks the current enable/busy conditions.
    case ({busy, enable})
      2'b11:   state_d = ST_RUN;
      2'b10:   state_d = ST_DRAIN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
    end else begin
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  // Skid-buffer storage: every returned word is written at the tail.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (inflight_q) begin
      buf_q[tail_q] <= rd_data;
    end else begin
      buf_q[tail_q] <= buf_q[tail_q];
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. A behavioural FIFO (one cycle read
// latency) feeds the DUT; expected beats are queued when words are loaded and
// a separate monitor pops and compares them whenever a beat is accepted. A
// second DUT built with BURST_LEN=1 shares all inputs and is checked beat by
// beat against the main one.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DW = 16;
  localparam int CW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst, enable, empty, out_ready;
  logic [DW-1:0] rd_data;

  logic          rd_en, out_valid, out_last, busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] word_cnt;
  logic [1:0]    drain_state;

  logic          rd_en1, out_valid1, out_last1, busy1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] word_cnt1;
  logic [1:0]    drain_state1;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(8), .CNT_WIDTH(CW)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .word_cnt(word_cnt), .drain_state(drain_state)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) u_dut1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .rd_en(rd_en1),
    .rd_data(rd_data), .empty(empty), .out_valid(out_valid1),
    .out_data(out_data1), .out_last(out_last1), .out_ready(out_ready),
    .busy(busy1), .word_cnt(word_cnt1), .drain_state(drain_state1)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            tests = 0;
  int            fails = 0;
  int            outstanding = 0;
  logic          s_rd_en, s_valid, s_busy;
  logic [DW-1:0] s_data;
  logic [1:0]    s_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic load_fifo(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
    empty = (fifo_q.size() == 0);
  endtask

  // One clock: apply inputs after the edge, sample at negedge, serve FIFO pop.
  task automatic cycle(input logic en, input logic rdy);
    logic ren, pop, exp_ren;
    enable    = en;
    out_ready = rdy;
    @(negedge rd_clk);
    pop     = out_valid & out_ready;
    exp_ren = !rd_rst && enable && !empty && ((outstanding - int'(pop)) < 2);
    chk("rd_en_rule", {63'd0, rd_en}, {63'd0, exp_ren});
    ren     = rd_en;
    s_rd_en = rd_en;
    s_valid = out_valid;
    s_busy  = busy;
    s_data  = out_data;
    s_state = drain_state;
    if (rd_rst) outstanding = 0;
    else        outstanding = outstanding + int'(ren) - int'(pop);
    @(posedge rd_clk);
    #1;
    if (ren && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  // Run until busy falls; pattern 0 = ready always, 1 = ready 1,0,0,1 repeating.
  task automatic run_idle(input logic en, input int pattern,
                          output int first_ren, output int first_val,
                          output int idle_at, output int nvalid);
    logic rdy;
    first_ren = -1;
    first_val = -1;
    idle_at   = -1;
    nvalid    = 0;
    for (int i = 0; i < 300; i++) begin
      rdy = (pattern == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      cycle(en, rdy);
      if (s_rd_en && first_ren < 0) first_ren = i;
      if (s_valid && first_val < 0) first_val = i;
      if (s_valid) nvalid++;
      if (i >= 2 && !s_busy) begin
        idle_at = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout: busy still %0b after 300 cycles, expected 0", s_busy);
  endtask

  // Scoreboard monitor: compares every accepted beat and stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge rd_clk) begin
    exp_t e;
    if (!rd_rst) begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", {48'd0, out_data}, {48'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {48'd0, out_data}, {48'd0, e.d});
          chk("beat_last", {63'd0, out_last}, {63'd0, e.l});
        end
      end
      chk("bl1_rd_en", {63'd0, rd_en1}, {63'd0, rd_en});
      chk("bl1_valid", {63'd0, out_valid1}, {63'd0, out_valid});
      chk("bl1_data", {48'd0, out_data1}, {48'd0, out_data});
      chk("bl1_last", {63'd0, out_last1}, {63'd0, out_valid1});
    end
    prev_stall = !rd_rst && out_valid && !out_ready;
    prev_data  = out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fv, ia, nv;
    rd_rst = 1'b1; enable = 1'b0; empty = 1'b1; out_ready = 1'b0; rd_data = '0;
    #1;
    // Reset state
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_data", {48'd0, out_data}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cnt", {32'd0, word_cnt}, 64'd0);
    chk("rst_fsm", {62'd0, drain_state}, 64'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rd_rst = 1'b0;

    // Test 1: 16 words, full throughput
    load_fifo(1, 16);
    for (int i = 1; i <= 16; i++) push_exp(DW'(i), (i % 8) == 0);
    run_idle(1'b1, 0, fr, fv, ia, nv);
    chk("t1_first_ren", 64'(fr), 64'd0);
    chk("t1_first_valid", 64'(fv), 64'd2);
    chk("t1_idle_at", 64'(ia), 64'd18);
    chk("t1_nvalid", 64'(nv), 64'd16);
    chk("t1_word_cnt", {32'd0, word_cnt}, 64'd16);
    chk("t1_fsm_run", {62'd0, s_state}, 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Test 2: back-pressure, ready 1,0,0,1
    load_fifo(1, 16);
    for (int i = 1; i <= 16; i++) push_exp(DW'(i), (i % 8) == 0);
    run_idle(1'b1, 1, fr, fv, ia, nv);
    chk("t2_word_cnt", {32'd0, word_cnt}, 64'd32);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Test 3: empty FIFO, then a single word
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      chk("t3_empty_rd_en", {63'd0, s_rd_en}, 64'd0);
      chk("t3_empty_valid", {63'd0, s_valid}, 64'd0);
    end
    fifo_q.push_back(16'hA5A5);
    empty = 1'b0;
    push_exp(16'hA5A5, 1'b0);
    cycle(1'b1, 1'b1);
    chk("t3_rd_en", {63'd0, s_rd_en}, 64'd1);
    cycle(1'b1, 1'b1);
    chk("t3_valid_n1", {63'd0, s_valid}, 64'd0);
    cycle(1'b1, 1'b1);
    chk("t3_valid_n2", {63'd0, s_valid}, 64'd1);
    chk("t3_data", {48'd0, s_data}, 64'h0000_0000_0000_A5A5);
    chk("t3_word_cnt", {32'd0, word_cnt}, 64'd33);

    // Test 4: drop enable mid-burst, then resume framing
    rd_rst = 1'b1;
    #1;
    chk("t4_rst_cnt", {32'd0, word_cnt}, 64'd0);
    cycle(1'b0, 1'b1);
    rd_rst = 1'b0;
    load_fifo(1, 8);
    for (int i = 1; i <= 8; i++) push_exp(DW'(i), i == 8);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    run_idle(1'b0, 0, fr, fv, ia, nv);
    chk("t4_drain_ren", 64'(fr), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_drain_beats", 64'(nv), 64'd2);
    chk("t4_drain_idle", 64'(ia), 64'd2);
    chk("t4_fsm_drain", {62'd0, s_state}, 64'd2);
    chk("t4_cnt5", {32'd0, word_cnt}, 64'd5);
    run_idle(1'b1, 0, fr, fv, ia, nv);
    chk("t4_resume_beats", 64'(nv), 64'd3);
    chk("t4_cnt8", {32'd0, word_cnt}, 64'd8);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Test 5: reset while the buffer holds two words
    rd_rst = 1'b1;
    #1;
    cycle(1'b0, 1'b1);
    rd_rst = 1'b0;
    load_fifo(1, 8);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    chk("t5_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_pre_rd_en", {63'd0, rd_en}, 64'd0);
    rd_rst = 1'b1;
    #1;
    chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("t5_rst_cnt", {32'd0, word_cnt}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    cycle(1'b1, 1'b0);
    rd_rst = 1'b0;
    load_fifo(9, 2);
    for (int i = 3; i <= 10; i++) push_exp(DW'(i), i == 10);
    run_idle(1'b1, 0, fr, fv, ia, nv);
    chk("t5_beats", 64'(nv), 64'd8);
    chk("t5_cnt", {32'd0, word_cnt}, 64'd8);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
